// File: rtl/store_align_unit.sv
// store_align_unit: turns a store request into word-aligned write beats with byte enables
module store_align_unit #(
   parameter bit ALLOW_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_data,
   input  logic [1:0]  i_req_size,
   output logic        o_mem_valid,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_we,
   output logic        o_done,
   output logic        o_err,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_req_ready;
   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_we;
   logic        r_done;
   logic        r_err;
   logic        r_busy;
   logic        r_split;
   logic [31:0] r_hi_addr;
   logic [31:0] r_hi_wdata;
   logic [3:0]  r_hi_we;

   logic [1:0]  w_off;
   logic [3:0]  w_base;
   logic [63:0] w_data64;
   logic [7:0]  w_mask8;
   logic        w_split;
   logic        w_reject;
   logic        w_accept;
   logic [31:0] w_lo_addr;
   logic        w_nxt_valid;
   logic [31:0] w_nxt_addr;
   logic [31:0] w_nxt_wdata;
   logic [3:0]  w_nxt_we;
   logic        w_nxt_done;
   logic        w_nxt_err;

   assign w_off     = i_req_addr[1:0];
   assign w_base    = (i_req_size == 2'b00) ? 4'b0001 : (i_req_size == 2'b01) ? 4'b0011 : 4'b1111;
   assign w_data64  = {32'b0, i_req_data} << {w_off, 3'b000};
   assign w_mask8   = {4'b0, w_base} << w_off;
   assign w_split   = |w_mask8[7:4];
   assign w_reject  = (i_req_size == 2'b11) || (w_split && !ALLOW_SPLIT);
   assign w_accept  = i_req_valid && r_req_ready;
   assign w_lo_addr = {i_req_addr[31:2], 2'b00};

   assign o_req_ready = r_req_ready;
   assign o_mem_valid = r_mem_valid;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = r_mem_we;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_busy      = r_busy;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next-state: accepted legal request -> BEAT0, each handshake advances a beat
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (w_accept && !w_reject) ? BEAT0 : IDLE;
         BEAT0:   w_next = i_mem_ready ? (r_split ? BEAT1 : IDLE) : BEAT0;
         BEAT1:   w_next = i_mem_ready ? IDLE : BEAT1;
         default: w_next = IDLE;
      endcase
   end

   // next output values: load beat0 on accept, swap in beat1 after beat0 handshake, hold while stalled
   always_comb begin
      w_nxt_valid = (w_next != IDLE);
      w_nxt_addr  = r_mem_addr;
      w_nxt_wdata = r_mem_wdata;
      w_nxt_we    = r_mem_we;
      if (w_next == IDLE) begin
         w_nxt_addr  = 32'd0;
         w_nxt_wdata = 32'd0;
         w_nxt_we    = 4'd0;
      end else if (r_state == IDLE) begin
         w_nxt_addr  = w_lo_addr;
         w_nxt_wdata = w_data64[31:0];
         w_nxt_we    = w_mask8[3:0];
      end else if (r_state == BEAT0 && w_next == BEAT1) begin
         w_nxt_addr  = r_hi_addr;
         w_nxt_wdata = r_hi_wdata;
         w_nxt_we    = r_hi_we;
      end
      w_nxt_done = i_mem_ready && ((r_state == BEAT0 && !r_split) || r_state == BEAT1);
      w_nxt_err  = w_accept && w_reject;
   end

   // registered outputs so nothing on the memory side depends combinationally on the request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_ready <= 1'b1;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_we    <= 4'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_req_ready <= (w_next == IDLE);
         r_mem_valid <= w_nxt_valid;
         r_mem_addr  <= w_nxt_addr;
         r_mem_wdata <= w_nxt_wdata;
         r_mem_we    <= w_nxt_we;
         r_done      <= w_nxt_done;
         r_err       <= w_nxt_err;
         r_busy      <= (w_next != IDLE);
      end
   end

   // upper-word beat captured at accept; the wrapped +4 address comes for free from 32-bit arithmetic
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_split    <= 1'b0;
         r_hi_addr  <= 32'd0;
         r_hi_wdata <= 32'd0;
         r_hi_we    <= 4'd0;
      end else if (w_accept) begin
         r_split    <= w_split;
         r_hi_addr  <= w_lo_addr + 32'd4;
         r_hi_wdata <= w_data64[63:32];
         r_hi_we    <= w_mask8[7:4];
      end
   end

endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: vector table, random stores against a byte-level model, and corner sequences
module tb_store_align_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid, b_req_valid, mem_ready;
   logic [31:0] req_addr, req_data;
   logic [1:0]  req_size;

   logic        a_req_ready, a_mem_valid, a_done, a_err, a_busy;
   logic [31:0] a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_we;
   logic        b_req_ready, b_mem_valid, b_done, b_err, b_busy;
   logic [31:0] b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_we;

   store_align_unit #(.ALLOW_SPLIT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
      .i_req_addr(req_addr), .i_req_data(req_data), .i_req_size(req_size),
      .o_mem_valid(a_mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(a_mem_addr),
      .o_mem_wdata(a_mem_wdata), .o_mem_we(a_mem_we), .o_done(a_done), .o_err(a_err), .o_busy(a_busy)
   );

   store_align_unit #(.ALLOW_SPLIT(1'b0)) dut_nosplit (
      .clk(clk), .rst_n(rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
      .i_req_addr(req_addr), .i_req_data(req_data), .i_req_size(req_size),
      .o_mem_valid(b_mem_valid), .i_mem_ready(1'b1), .o_mem_addr(b_mem_addr),
      .o_mem_wdata(b_mem_wdata), .o_mem_we(b_mem_we), .o_done(b_done), .o_err(b_err), .o_busy(b_busy)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
   } beat_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic [3:0]  stall;
      logic [1:0]  nb;
      logic        err;
      beat_t       b0;
      beat_t       b1;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // byte-by-byte reference: each byte of the store lands in lane (addr+i)%4 of word (addr+i)/4
   function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                 input bit allow, output logic [1:0] nb, output logic err,
                                 output beat_t b0, output beat_t b1);
      logic [31:0] ba, w0, w1, a1;
      logic [3:0]  e0, e1;
      logic [7:0]  dbytes [4];
      int n;
      w0 = '0; w1 = '0; e0 = '0; e1 = '0; a1 = '0;
      b0 = '0; b1 = '0; nb = 2'd0; err = 1'b0;
      for (int i = 0; i < 4; i++) dbytes[i] = d[8*i +: 8];
      if (sz == 2'b11) begin
         err = 1'b1;
         return;
      end
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         if ((ba & ~32'd3) == (a & ~32'd3)) begin
            w0[8*ba[1:0] +: 8] = dbytes[i];
            e0[ba[1:0]] = 1'b1;
         end else begin
            a1 = ba & ~32'd3;
            w1[8*ba[1:0] +: 8] = dbytes[i];
            e1[ba[1:0]] = 1'b1;
         end
      end
      b0 = '{a & ~32'd3, w0, e0};
      b1 = '{a1, w1, e1};
      nb = (e1 != 4'd0) ? 2'd2 : 2'd1;
      if (nb == 2'd2 && !allow) begin
         err = 1'b1;
         nb = 2'd0;
         b0 = '0;
         b1 = '0;
      end
   endfunction

   // drives one request into the split-capable unit and collects what the memory side saw
   task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input int stall,
                         output int nb, output beat_t ob0, output beat_t ob1,
                         output int n_done, output int done_cyc, output int n_err, output int err_cyc);
      beat_t prev, cur;
      logic  held;
      int    st, viol;
      nb = 0; ob0 = '0; ob1 = '0; n_done = 0; n_err = 0; done_cyc = 0; err_cyc = 0;
      held = 1'b0; st = stall; viol = 0; prev = '0;
      @(negedge clk);
      chk("req_ready_idle", 32'(a_req_ready), 32'd1);
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz; mem_ready = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         mem_ready = 1'b0;
         if (a_done) begin n_done++; done_cyc = c; end
         if (a_err) begin n_err++; err_cyc = c; end
         if (a_done && a_err) viol++;
         if (a_mem_valid) begin
            cur = '{a_mem_addr, a_mem_wdata, a_mem_we};
            if (held && cur != prev) viol++;
            if (a_req_ready || !a_busy) viol++;
            if (st > 0) begin
               st--;
               held = 1'b1;
               prev = cur;
               req_valid = 1'b1;
               req_addr = $urandom;
               req_data = $urandom;
               req_size = 2'($urandom);
            end else begin
               mem_ready = 1'b1;
               held = 1'b0;
               if (nb == 0) ob0 = cur;
               else if (nb == 1) ob1 = cur;
               nb++;
               st = stall;
            end
         end else if (n_done + n_err > 0) begin
            break;
         end
      end
      chk("terminated", 32'(n_done + n_err > 0), 32'd1);
      chk("stall_stable_no_overlap", 32'(viol), 32'd0);
      @(negedge clk);
      chk("idle_after", 32'({a_mem_valid, a_done, a_err, a_req_ready, a_busy}), 32'b00010);
   endtask

   task automatic run(input string tag, input vec_t v);
      int nb, n_done, done_cyc, n_err, err_cyc;
      beat_t ob0, ob1;
      do_req(v.addr, v.data, v.size, int'(v.stall), nb, ob0, ob1, n_done, done_cyc, n_err, err_cyc);
      chk({tag, "_nbeats"}, 32'(nb), 32'(v.nb));
      if (v.nb >= 2'd1) begin
         chk({tag, "_b0addr"}, ob0.addr, v.b0.addr);
         chk({tag, "_b0wdata"}, ob0.wdata, v.b0.wdata);
         chk({tag, "_b0we"}, 32'(ob0.we), 32'(v.b0.we));
      end
      if (v.nb == 2'd2) begin
         chk({tag, "_b1addr"}, ob1.addr, v.b1.addr);
         chk({tag, "_b1wdata"}, ob1.wdata, v.b1.wdata);
         chk({tag, "_b1we"}, 32'(ob1.we), 32'(v.b1.we));
      end
      chk({tag, "_ndone"}, 32'(n_done), v.err ? 32'd0 : 32'd1);
      chk({tag, "_nerr"}, 32'(n_err), v.err ? 32'd1 : 32'd0);
      if (v.err) chk({tag, "_errcyc"}, 32'(err_cyc), 32'd1);
      else       chk({tag, "_donecyc"}, 32'(done_cyc), 32'(1 + int'(v.nb) * (int'(v.stall) + 1)));
   endtask

   // single request into the no-split unit, whose memory side is always ready
   task automatic b_req(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic exp_err, input beat_t eb);
      @(negedge clk);
      req_addr = a; req_data = d; req_size = sz; b_req_valid = 1'b1;
      @(negedge clk);
      b_req_valid = 1'b0;
      chk({tag, "_t1_err"}, 32'(b_err), 32'(exp_err));
      chk({tag, "_t1_valid"}, 32'(b_mem_valid), 32'(!exp_err));
      chk({tag, "_t1_ready"}, 32'(b_req_ready), 32'(exp_err));
      if (!exp_err) begin
         chk({tag, "_addr"}, b_mem_addr, eb.addr);
         chk({tag, "_wdata"}, b_mem_wdata, eb.wdata);
         chk({tag, "_we"}, 32'(b_mem_we), 32'(eb.we));
      end
      @(negedge clk);
      chk({tag, "_t2"}, 32'({b_mem_valid, b_done, b_err, b_req_ready}), {28'd0, 1'b0, !exp_err, 1'b0, 1'b1});
   endtask

   vec_t vecs [8];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic [1:0] nb;
      logic e;
      beat_t m0, m1;
      req_valid = 1'b0; b_req_valid = 1'b0; mem_ready = 1'b0;
      req_addr = '0; req_data = '0; req_size = '0;

      vecs[0] = '{32'h0000_1002, 32'h0000_00AB, 2'd0, 4'd0, 2'd1, 1'b0,
                  '{32'h0000_1000, 32'h00AB_0000, 4'b0100}, '0};
      vecs[1] = '{32'h0000_2003, 32'h0000_1234, 2'd1, 4'd0, 2'd2, 1'b0,
                  '{32'h0000_2000, 32'h3400_0000, 4'b1000}, '{32'h0000_2004, 32'h0000_0012, 4'b0001}};
      vecs[2] = '{32'hFFFF_FFFE, 32'hDEAD_BEEF, 2'd2, 4'd0, 2'd2, 1'b0,
                  '{32'hFFFF_FFFC, 32'hBEEF_0000, 4'b1100}, '{32'h0000_0000, 32'h0000_DEAD, 4'b0011}};
      vecs[3] = '{32'h0000_3001, 32'hDEAD_BEEF, 2'd2, 4'd3, 2'd2, 1'b0,
                  '{32'h0000_3000, 32'hADBE_EF00, 4'b1110}, '{32'h0000_3004, 32'h0000_00DE, 4'b0001}};
      vecs[4] = '{32'h0000_1234, 32'h5555_AAAA, 2'd3, 4'd0, 2'd0, 1'b1, '0, '0};
      vecs[5] = '{32'h0000_0003, 32'h0000_0077, 2'd3, 4'd0, 2'd0, 1'b1, '0, '0};
      vecs[6] = '{32'h0000_0010, 32'hCAFE_F00D, 2'd2, 4'd1, 2'd1, 1'b0,
                  '{32'h0000_0010, 32'hCAFE_F00D, 4'b1111}, '0};
      vecs[7] = '{32'h0000_0002, 32'h0000_BEEF, 2'd1, 4'd0, 2'd1, 1'b0,
                  '{32'h0000_0000, 32'hBEEF_0000, 4'b1100}, '0};

      repeat (2) @(negedge clk);
      chk("rst_flags", 32'({a_req_ready, a_mem_valid, a_done, a_err, a_busy}), 32'b10000);
      chk("rst_addr", a_mem_addr, 32'd0);
      chk("rst_wdata", a_mem_wdata, 32'd0);
      chk("rst_we", 32'(a_mem_we), 32'd0);
      chk("rst_b_flags", 32'({b_req_ready, b_mem_valid, b_done, b_err, b_busy}), 32'b10000);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run($sformatf("vec%0d", i), vecs[i]);

      for (int i = 0; i < 150; i++) begin
         v = '0;
         v.addr = $urandom;
         v.size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         v.data = $urandom;
         if (v.size == 2'd0) v.data = v.data & 32'hFF;
         if (v.size == 2'd1) v.data = v.data & 32'hFFFF;
         v.stall = 4'($urandom_range(0, 2));
         model(v.addr, v.data, v.size, 1'b1, nb, e, m0, m1);
         v.nb = nb; v.err = e; v.b0 = m0; v.b1 = m1;
         run($sformatf("rnd%0d", i), v);
      end

      model(32'h0000_0003, 32'h0000_1234, 2'd1, 1'b0, nb, e, m0, m1);
      b_req("ns_sh3", 32'h0000_0003, 32'h0000_1234, 2'd1, e, m0);
      b_req("ns_sz3", 32'h0000_0040, 32'h1111_2222, 2'd3, 1'b1, '0);
      model(32'h0000_0020, 32'hA5A5_5A5A, 2'd2, 1'b0, nb, e, m0, m1);
      b_req("ns_sw", 32'h0000_0020, 32'hA5A5_5A5A, 2'd2, e, m0);
      model(32'h0000_0001, 32'h0000_1234, 2'd1, 1'b0, nb, e, m0, m1);
      b_req("ns_sh1", 32'h0000_0001, 32'h0000_1234, 2'd1, e, m0);

      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_2003; req_data = 32'h0000_1234; req_size = 2'd1; mem_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_b0addr", a_mem_addr, 32'h0000_2000);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("mid_b1addr", a_mem_addr, 32'h0000_2004);
      chk("mid_b1valid", 32'(a_mem_valid), 32'd1);
      mem_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 32'({a_req_ready, a_mem_valid, a_done, a_err, a_busy}), 32'b10000);
      chk("mid_rst_addr", a_mem_addr, 32'd0);
      chk("mid_rst_wdata", a_mem_wdata, 32'd0);
      chk("mid_rst_we", 32'(a_mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{32'h0000_0010, 32'h1122_3344, 2'd2, 4'd0, 2'd1, 1'b0,
            '{32'h0000_0010, 32'h1122_3344, 4'b1111}, '0};
      run("post_rst_sw", v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
